// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-lane traffic light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    GREEN_S,
    YELLOW_S,
    CLEAR_S
  } state_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/traffic_light_controller_n_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// moves past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!grant_valid && req[IW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt   = 32'(grant_idx) + 1;
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (nxt >= N) ? '0 : IW'(nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-lane round-robin traffic light controller with min/gap/max green timing
// and an all-red pre-emption input. All outputs are registered.
module traffic_light_controller_n
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 3,
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned MAX_GREEN     = 8,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned CLEAR_CYCLES  = 1,
  parameter int unsigned LW            = $clog2(NUM_LANES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_LANES-1:0]   sensor,
  input  logic                   hold_red,
  output logic [2*NUM_LANES-1:0] lights,
  output logic [LW-1:0]          active_lane,
  output logic                   busy
);

  localparam int unsigned M1   = (MAX_GREEN > GAP_CYCLES) ? MAX_GREEN : GAP_CYCLES;
  localparam int unsigned M2   = (YELLOW_CYCLES > CLEAR_CYCLES) ? YELLOW_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CW   = cnt_width((M1 > M2) ? M1 : M2);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_GREEN);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_GREEN);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] YEL_C = CW'(YELLOW_CYCLES);
  localparam logic [CW-1:0] CLR_C = CW'(CLEAR_CYCLES);

  state_t                   state_q, state_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [CW-1:0]            green_cnt_q, green_cnt_d;
  logic [CW-1:0]            gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]            phase_cnt_q, phase_cnt_d;
  logic [2*NUM_LANES-1:0]   lights_q, lights_d;
  logic [LW-1:0]            active_q, active_d;
  logic                     busy_q, busy_d;

  logic [NUM_LANES-1:0]     other_req;
  logic                     arb_adv;
  logic [LW-1:0]            grant_idx;
  logic                     grant_valid;

  rr_arbiter #(
    .N  (NUM_LANES),
    .IW (LW)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (sensor),
    .advance     (arb_adv),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    green_cnt_d = green_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    phase_cnt_d = phase_cnt_q;
    arb_adv     = 1'b0;
    other_req   = sensor;
    other_req[lane_q] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!hold_red && grant_valid) begin
          state_d     = GREEN_S;
          lane_d      = grant_idx;
          green_cnt_d = CW'(1);
          gap_cnt_d   = '0;
          arb_adv     = 1'b1;
        end
      end
      GREEN_S: begin
        // Exit uses the counts for cycles already served; updates follow.
        if (hold_red ||
            (green_cnt_q >= MIN_C && gap_cnt_q >= GAP_C) ||
            (green_cnt_q >= MAX_C && |other_req)) begin
          state_d     = YELLOW_S;
          phase_cnt_d = CW'(1);
          green_cnt_d = '0;
          gap_cnt_d   = '0;
        end else begin
          green_cnt_d = (green_cnt_q >= MAX_C) ? green_cnt_q : green_cnt_q + 1'b1;
          if (sensor[lane_q]) begin
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = (gap_cnt_q >= GAP_C) ? gap_cnt_q : gap_cnt_q + 1'b1;
          end
        end
      end
      YELLOW_S: begin
        if (phase_cnt_q >= YEL_C) begin
          state_d     = CLEAR_S;
          phase_cnt_d = CW'(1);
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      CLEAR_S: begin
        if (phase_cnt_q >= CLR_C) begin
          phase_cnt_d = '0;
          state_d     = IDLE;
          if (!hold_red && grant_valid) begin
            state_d     = GREEN_S;
            lane_d      = grant_idx;
            green_cnt_d = CW'(1);
            gap_cnt_d   = '0;
            arb_adv     = 1'b1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lights_d = '0;
    active_d = '0;
    busy_d   = (state_d != IDLE);
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (LW'(i) == lane_d) begin
        if (state_d == GREEN_S) begin
          lights_d[2*i +: 2] = GREEN;
          active_d           = lane_d;
        end else if (state_d == YELLOW_S) begin
          lights_d[2*i +: 2] = YELLOW;
          active_d           = lane_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      green_cnt_q <= '0;
      gap_cnt_q   <= '0;
      phase_cnt_q <= '0;
      lights_q    <= '0;
      active_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      green_cnt_q <= green_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      lights_q    <= lights_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
    end
  end

  assign lights      = lights_q;
  assign active_lane = active_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Bench for traffic_light_controller_n: directed scenarios plus random traffic,
// all outputs compared each cycle against a phase/age reference model.
module tb_traffic_light_controller_n;

  localparam int N     = 3;
  localparam int MIN_G = 4;
  localparam int MAX_G = 8;
  localparam int GAP   = 2;
  localparam int YEL   = 2;
  localparam int CLR   = 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   sensor;
  logic           hold_red;
  logic [2*N-1:0] lights;
  logic [1:0]     active_lane;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Model: phase 0=all red idle, 1=green, 2=yellow, 3=clearance.
  int m_phase = 0, m_lane = 0, m_age = 0, m_gap = 0, m_ptr = 0;

  int             grants[$];
  logic [2*N-1:0] prev_lights;
  int             g0_cycles;

  traffic_light_controller_n #(
    .NUM_LANES     (N),
    .MIN_GREEN     (MIN_G),
    .MAX_GREEN     (MAX_G),
    .GAP_CYCLES    (GAP),
    .YELLOW_CYCLES (YEL),
    .CLEAR_CYCLES  (CLR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor      (sensor),
    .hold_red    (hold_red),
    .lights      (lights),
    .active_lane (active_lane),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_grant(input logic [N-1:0] s);
    for (int i = 0; i < N; i++) begin
      int l;
      l = (m_ptr + i) % N;
      if (s[l]) begin
        m_lane  = l;
        m_ptr   = (l + 1) % N;
        m_phase = 1;
        m_age   = 1;
        m_gap   = 0;
        return;
      end
    end
  endtask

  task automatic m_step(input logic [N-1:0] s, input logic h);
    logic [N-1:0] others;
    others = s;
    others[m_lane] = 1'b0;
    case (m_phase)
      0: if (!h && s != 0) m_grant(s);
      1: begin
        if (h || (m_age >= MIN_G && m_gap >= GAP) || (m_age >= MAX_G && others != 0)) begin
          m_phase = 2;
          m_age   = 1;
        end else begin
          m_age++;
          m_gap = s[m_lane] ? 0 : m_gap + 1;
        end
      end
      2: if (m_age >= YEL) begin m_phase = 3; m_age = 1; end else m_age++;
      default: begin
        if (m_age >= CLR) begin
          m_phase = 0;
          if (!h && s != 0) m_grant(s);
        end else m_age++;
      end
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_lane = 0; m_age = 0; m_gap = 0; m_ptr = 0;
    end else begin
      m_step(sensor, hold_red);
    end
  end

  function automatic logic [2*N-1:0] exp_lights();
    logic [2*N-1:0] r;
    r = '0;
    if (m_phase == 1) r[2*m_lane +: 2] = 2'd2;
    if (m_phase == 2) r[2*m_lane +: 2] = 2'd1;
    return r;
  endfunction

  task automatic compare_all();
    int nonred;
    bit bad3;
    nonred = 0;
    bad3   = 0;
    check("lights", lights, exp_lights());
    check("active", active_lane, (m_phase == 1 || m_phase == 2) ? m_lane : 0);
    check("busy", busy, m_phase != 0);
    for (int i = 0; i < N; i++) begin
      if (lights[2*i +: 2] != 2'd0) nonred++;
      if (lights[2*i +: 2] == 2'd3) bad3 = 1;
      if (lights[2*i +: 2] == 2'd2 && prev_lights[2*i +: 2] != 2'd2) grants.push_back(i);
    end
    check("legal", (nonred <= 1) && !bad3, 1);
    if (lights[1:0] == 2'd2) g0_cycles++;
    prev_lights = lights;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    sensor   = '0;
    hold_red = 1'b0;
    @(negedge clk);
    check("rst_lights", lights, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    prev_lights = '0;
    grants.delete();
    g0_cycles = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    sensor   = '0;
    hold_red = 1'b0;
    prev_lights = '0;
    g0_cycles = 0;
    repeat (2) @(negedge clk);
    check("rst_active", active_lane, 0);
    do_reset();

    // 1: short request on lane 0
    sensor = 3'b001; cycles(2);
    sensor = 3'b000; cycles(12);
    check("s1_green_len", g0_cycles, 4);

    // 2: all lanes held, round robin with max-green yield
    do_reset();
    sensor = 3'b111; cycles(44);
    check("s2_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
      check("s2_g0", grants[0], 0);
      check("s2_g1", grants[1], 1);
      check("s2_g2", grants[2], 2);
      check("s2_g3", grants[3], 0);
    end
    sensor = 3'b000; cycles(15);

    // 3: lone lane held stays green, then gaps out
    do_reset();
    sensor = 3'b010; cycles(40);
    check("s3_still_green", lights, 6'b001000);
    sensor = 3'b000; cycles(8);
    check("s3_ngrants", grants.size(), 1);

    // 4: pre-emption during early green of lane 2
    do_reset();
    sensor = 3'b100; cycles(2);
    hold_red = 1'b1; sensor = 3'b111; cycles(10);
    check("s4_held_red", lights, 0);
    grants.delete();
    hold_red = 1'b0; cycles(3);
    check("s4_ngrants", grants.size(), 1);
    if (grants.size() >= 1) check("s4_resume", grants[0], 0);
    sensor = 3'b000; cycles(20);

    // 5: asynchronous reset mid-yellow
    do_reset();
    sensor = 3'b001; cycles(2);
    sensor = 3'b000; cycles(3);
    check("s5_yellow", lights[1:0], 1);
    #2 reset_n = 1'b0;
    #1;
    check("s5_async_lights", lights, 0);
    check("s5_async_busy", busy, 0);
    check("s5_async_active", active_lane, 0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_lights = '0;
    grants.delete();
    sensor = 3'b110; cycles(3);
    check("s5_ngrants", grants.size(), 1);
    if (grants.size() >= 1) check("s5_first", grants[0], 1);
    sensor = 3'b000; cycles(20);

    // 6: competing request arrives mid-green
    do_reset();
    sensor = 3'b001; cycles(5);
    sensor = 3'b101; cycles(20);
    check("s6_ngrants", grants.size() >= 2, 1);
    if (grants.size() >= 2) check("s6_second", grants[1], 2);
    sensor = 3'b000; cycles(40);

    // Random traffic with occasional pre-emption
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if (k % 4 == 0) sensor = N'($urandom);
      if ($urandom_range(0, 24) == 0) hold_red = ~hold_red;
      cycles(1);
    end
    hold_red = 1'b0;
    sensor   = '0;
    cycles(30);
    check("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
